// File: rtl/phys_reg_free_list_mw.sv
`default_nettype none
// ============================================================================
// Module      : phys_reg_free_list_mw
// Description : Multi-ported physical register free list with per-lane revert
//               and ROB-tagged head checkpoints for mispredict recovery.
//               Optional same-cycle enqueue->dequeue bypass: PRFL_ENQ_BYPASS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module phys_reg_free_list_mw #(
    parameter int NUM_PHYS_REGS   = 64,
    parameter int NUM_ARCH_REGS   = 32,
    parameter int DEQ_WIDTH       = 2,
    parameter int ENQ_WIDTH       = 2,
    parameter int NUM_CHECKPOINTS = 4,
    parameter int ROB_INDEX_W     = 5,
    localparam int TAG_W          = $clog2(NUM_PHYS_REGS),
    localparam int COL_W          = $clog2(NUM_CHECKPOINTS),
    localparam int RCNT_W         = $clog2(DEQ_WIDTH + 1)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DEQ_WIDTH-1:0]         deq_valid,
    output logic [DEQ_WIDTH-1:0]         deq_ready,
    output logic [DEQ_WIDTH*TAG_W-1:0]   deq_tag,
    input  logic [ENQ_WIDTH-1:0]         enq_valid,
    input  logic [ENQ_WIDTH*TAG_W-1:0]   enq_tag,
    input  logic                         revert_valid,
    input  logic [RCNT_W-1:0]            revert_count,
    input  logic                         save_valid,
    input  logic [ROB_INDEX_W-1:0]       save_rob_index,
    output logic                         save_ready,
    output logic [COL_W-1:0]             save_column,
    input  logic                         restore_valid,
    input  logic                         restore_speculate_failed,
    input  logic [COL_W-1:0]             restore_column,
    input  logic [ROB_INDEX_W-1:0]       restore_rob_index,
    output logic                         restore_success,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow_err
);

    localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);

    logic [TAG_W-1:0]       r_entry   [DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [NUM_CHECKPOINTS-1:0] r_ck_valid;
    logic [PTR_W-1:0]       r_ck_head [NUM_CHECKPOINTS];
    logic [ROB_INDEX_W-1:0] r_ck_rob  [NUM_CHECKPOINTS];
    logic [COL_W-1:0]       r_alloc;
    logic                   r_overflow;

    logic [PTR_W-1:0]       w_count;
    logic [PTR_W-1:0]       w_n_deq;
    logic [PTR_W-1:0]       w_n_enq;
    logic [PTR_W-1:0]       w_head_next;
    logic [PTR_W-1:0]       w_tail_next;
    logic [PTR_W:0]         w_occ_next;
    logic                   w_enq_drop;
    logic [ENQ_WIDTH-1:0]   w_enq_we;
    logic                   w_restore_hit;
    logic                   w_restore_fail;
    logic                   w_save_fire;
    logic [COL_W-1:0]       w_dist_alloc;
    logic [NUM_CHECKPOINTS-1:0] w_ck_kill;
    logic [NUM_CHECKPOINTS-1:0] w_ck_valid_next;
    logic [COL_W-1:0]       w_alloc_next;

    assign w_count         = r_tail - r_head;
    assign full            = (w_count == C_DEPTH);
    assign empty           = (w_count == '0);
    assign overflow_err    = r_overflow;
    assign save_ready      = !r_ck_valid[r_alloc];
    assign save_column     = r_alloc;

    assign w_restore_hit   = restore_valid && r_ck_valid[restore_column] &&
                             (r_ck_rob[restore_column] == restore_rob_index);
    assign restore_success = w_restore_hit;
    assign w_restore_fail  = w_restore_hit && restore_speculate_failed;
    assign w_save_fire     = save_valid && save_ready && !w_restore_fail;

    always_comb begin
        w_n_enq = '0;
        for (int j = 0; j < ENQ_WIDTH; j++) begin
            w_n_enq = w_n_enq + PTR_W'(enq_valid[j]);
        end
    end

    always_comb begin
        deq_ready = '0;
        deq_tag   = '0;
        w_n_deq   = '0;
        for (int i = 0; i < DEQ_WIDTH; i++) begin
`ifdef PRFL_ENQ_BYPASS_EN
            deq_ready[i] = ({1'b0, w_count} + {1'b0, w_n_enq}) > (PTR_W+1)'(i);
            if (PTR_W'(i) < w_count) begin
                deq_tag[i*TAG_W +: TAG_W] = r_entry[IDX_W'(r_head + PTR_W'(i))];
            end else begin
                // Lanes beyond the stored entries take the retiring tags in order
                for (int j = 0; j < ENQ_WIDTH; j++) begin
                    if ((PTR_W'(i) - w_count) == PTR_W'(j)) begin
                        deq_tag[i*TAG_W +: TAG_W] = enq_tag[j*TAG_W +: TAG_W];
                    end
                end
            end
`else
            deq_ready[i] = w_count > PTR_W'(i);
            deq_tag[i*TAG_W +: TAG_W] = r_entry[IDX_W'(r_head + PTR_W'(i))];
`endif
            w_n_deq = w_n_deq + PTR_W'(deq_valid[i] & deq_ready[i]);
        end
    end

    // Mispredict recovery beats revert, revert beats normal allocation
    always_comb begin
        w_head_next = r_head + w_n_deq;
        if (w_restore_fail) begin
            w_head_next = r_ck_head[restore_column];
        end else if (revert_valid) begin
            w_head_next = r_head - PTR_W'(revert_count);
        end
    end

    assign w_occ_next  = {1'b0, r_tail - w_head_next} + {1'b0, w_n_enq};
    assign w_enq_drop  = w_occ_next > (PTR_W+1)'(DEPTH);
    assign w_tail_next = w_enq_drop ? r_tail : r_tail + w_n_enq;

`ifdef PRFL_ENQ_BYPASS_EN
    logic             w_deq_fire;
    logic [PTR_W-1:0] w_n_byp;
    assign w_deq_fire = !w_restore_fail && !revert_valid;
    assign w_n_byp    = (w_deq_fire && (w_n_deq > w_count)) ? (w_n_deq - w_count) : '0;
`endif

    always_comb begin
        w_enq_we = '0;
        for (int j = 0; j < ENQ_WIDTH; j++) begin
            w_enq_we[j] = enq_valid[j] && !w_enq_drop;
`ifdef PRFL_ENQ_BYPASS_EN
            if (PTR_W'(j) < w_n_byp) begin
                w_enq_we[j] = 1'b0;
            end
`endif
        end
    end

    // A failed restore frees its column and every younger one up to the alloc pointer
    assign w_dist_alloc = r_alloc - restore_column;

    always_comb begin
        w_ck_kill = '0;
        if (w_restore_hit) begin
            if (restore_speculate_failed) begin
                for (int k = 0; k < NUM_CHECKPOINTS; k++) begin
                    if ((w_dist_alloc == '0) ||
                        (COL_W'(COL_W'(k) - restore_column) < w_dist_alloc)) begin
                        w_ck_kill[k] = 1'b1;
                    end
                end
            end else begin
                w_ck_kill[restore_column] = 1'b1;
            end
        end
    end

    always_comb begin
        w_ck_valid_next = r_ck_valid & ~w_ck_kill;
        w_alloc_next    = r_alloc;
        if (w_restore_fail) begin
            w_alloc_next = restore_column;
        end else if (w_save_fire) begin
            w_ck_valid_next[r_alloc] = 1'b1;
            w_alloc_next = (r_alloc == COL_W'(NUM_CHECKPOINTS - 1)) ? '0 : r_alloc + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_entry[k] <= TAG_W'(NUM_ARCH_REGS + k);
            end
            for (int c = 0; c < NUM_CHECKPOINTS; c++) begin
                r_ck_head[c] <= '0;
                r_ck_rob[c]  <= '0;
            end
            r_head     <= '0;
            r_tail     <= C_DEPTH;
            r_ck_valid <= '0;
            r_alloc    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
            r_ck_valid <= w_ck_valid_next;
            r_alloc    <= w_alloc_next;
            if (w_enq_drop) begin
                r_overflow <= 1'b1;
            end
            for (int j = 0; j < ENQ_WIDTH; j++) begin
                if (w_enq_we[j]) begin
                    r_entry[IDX_W'(r_tail + PTR_W'(j))] <= enq_tag[j*TAG_W +: TAG_W];
                end
            end
            if (w_save_fire) begin
                r_ck_head[r_alloc] <= w_head_next;
                r_ck_rob[r_alloc]  <= save_rob_index;
            end
        end
    end

endmodule
`default_nettype wire
